// File: rtl/reel_pkg.sv
// Shared definitions for the reel counter array: controller states and
// default parameter values.
package reel_pkg;

    localparam int DEF_N_CH    = 3;
    localparam int DEF_DIGIT_W = 4;
    localparam int DEF_MODULO  = 10;
    localparam int DEF_PRESC_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SPIN   = 2'd1,
        RESULT = 2'd2
    } state_t;

endpackage

// File: rtl/reel_channel.sv
// One reel: a prescale counter that advances a modulo digit once every
// `presc` enabled cycles.
module reel_channel
    import reel_pkg::*;
#(
    parameter int DIGIT_W = DEF_DIGIT_W,
    parameter int MODULO  = DEF_MODULO,
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [PRESC_W-1:0] presc,
    output logic [DIGIT_W-1:0] digit
);

    logic [PRESC_W-1:0] r_count;
    logic [DIGIT_W-1:0] r_digit;
    logic [PRESC_W-1:0] w_presc_eff;
    logic               w_step;

    // A zero prescale would never match count-1, so it behaves as one.
    assign w_presc_eff = (presc == '0) ? PRESC_W'(1) : presc;
    assign w_step      = (r_count == w_presc_eff - PRESC_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
            r_digit <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            if (w_step) begin
                r_count <= '0;
                r_digit <= (r_digit == DIGIT_W'(MODULO - 1)) ? '0 : r_digit + DIGIT_W'(1);
            end else begin
                r_count <= r_count + PRESC_W'(1);
            end
        end
    end

    assign digit = r_digit;

endmodule

// File: rtl/reel_counter_array.sv
// Array of independently prescaled digit reels with a start/stop/result
// controller and an all-digits-equal win flag.
module reel_counter_array
    import reel_pkg::*;
#(
    parameter int N_CH    = DEF_N_CH,
    parameter int DIGIT_W = DEF_DIGIT_W,
    parameter int MODULO  = DEF_MODULO,
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic [N_CH*PRESC_W-1:0] presc,
    output logic [N_CH*DIGIT_W-1:0] digits,
    output logic [N_CH-1:0]         running,
    output logic                    busy,
    output logic                    done,
    output logic                    win
);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [N_CH*PRESC_W-1:0] r_presc;
    logic [N_CH-1:0]         r_running;
    logic                    r_win;

    logic                    w_accept;
    logic                    w_stop_hit;
    logic [N_CH-1:0]         w_stop_sel;
    logic [N_CH-1:0]         w_running_next;
    logic                    w_all_equal;

    assign w_accept   = (r_state == IDLE) && start;
    assign w_stop_hit = (r_state == SPIN) && stop;

    // Isolate the lowest set running bit: x & -x.
    assign w_stop_sel     = w_stop_hit ? (r_running & (~r_running + N_CH'(1))) : '0;
    assign w_running_next = r_running & ~w_stop_sel;

    // NOTE: every variable written in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_all_equal = 1'b1;
        for (int i = 1; i < N_CH; i++) begin
            if (digits[i*DIGIT_W +: DIGIT_W] != digits[DIGIT_W-1:0]) begin
                w_all_equal = 1'b0;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next_state = SPIN;
            SPIN:    if (stop && (w_running_next == '0)) w_next_state = RESULT;
            RESULT:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: reset is synchronous; only control and latched-config registers
    // are cleared here, the channels clear their own state on the same rst_n.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_presc   <= '0;
            r_running <= '0;
            r_win     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_presc   <= presc;
                r_running <= '1;
                r_win     <= 1'b0;
            end else begin
                r_running <= w_running_next;
                // Digits are already frozen here: the stopping channel's step is suppressed.
                if ((r_state == SPIN) && (w_next_state == RESULT)) begin
                    r_win <= w_all_equal;
                end
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        reel_channel #(
            .DIGIT_W (DIGIT_W),
            .MODULO  (MODULO),
            .PRESC_W (PRESC_W)
        ) u_channel (
            .clk    (clk),
            .rst_n  (rst_n),
            .clear  (w_accept),
            .enable (r_running[g] & ~w_stop_sel[g]),
            .presc  (r_presc[g*PRESC_W +: PRESC_W]),
            .digit  (digits[g*DIGIT_W +: DIGIT_W])
        );
    end

    assign running = r_running;
    assign busy    = (r_state != IDLE);
    assign done    = (r_state == RESULT);
    assign win     = r_win;

endmodule

// File: tb/tb_reel_counter_array.sv
// Scenario-driven bench for reel_counter_array with a queue of expected
// digit/running snapshots.
module tb_reel_counter_array;

    localparam int N_CH    = 3;
    localparam int DIGIT_W = 4;
    localparam int MODULO  = 10;
    localparam int PRESC_W = 32;

    logic                    clk;
    logic                    rst_n;
    logic                    start;
    logic                    stop;
    logic [N_CH*PRESC_W-1:0] presc;
    logic [N_CH*DIGIT_W-1:0] digits;
    logic [N_CH-1:0]         running;
    logic                    busy;
    logic                    done;
    logic                    win;

    typedef struct {
        string                   name;
        logic [N_CH*DIGIT_W-1:0] digits;
        logic [N_CH-1:0]         running;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   checks;
    int   errors;
    int   done_cnt;
    int   done_base;

    reel_counter_array #(
        .N_CH    (N_CH),
        .DIGIT_W (DIGIT_W),
        .MODULO  (MODULO),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .presc   (presc),
        .digits  (digits),
        .running (running),
        .busy    (busy),
        .done    (done),
        .win     (win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt = done_cnt + 1;
    end

    function automatic logic [N_CH*PRESC_W-1:0] pack_presc(int p2, int p1, int p0);
        return {PRESC_W'(p2), PRESC_W'(p1), PRESC_W'(p0)};
    endfunction

    function automatic logic [N_CH*DIGIT_W-1:0] pack_dig(int d2, int d1, int d0);
        return {DIGIT_W'(d2), DIGIT_W'(d1), DIGIT_W'(d0)};
    endfunction

    // Digit after n enabled cycles from start value d0 with prescale p.
    function automatic int model_digit(int d0, int n, int p);
        int pe;
        pe = (p == 0) ? 1 : p;
        return (d0 + n / pe) % MODULO;
    endfunction

    task automatic tick(int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        presc = pack_presc(7, 5, 3);
        do_reset();
        checks++;
        if (digits !== '0 || running !== '0) begin
            errors++;
            $display("FAIL reset_state digits=%h running=%b required digits=0 running=0", digits, running);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || win !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags busy=%b done=%b win=%b required 0 0 0", busy, done, win);
        end
    endtask

    task automatic test_spin();
        do_reset();
        presc = pack_presc(3, 2, 1);
        pulse_start();
        tick(12);
        sb_q.push_back('{"spin12", pack_dig(model_digit(0, 12, 3), model_digit(0, 12, 2),
                                            model_digit(0, 12, 1)), 3'b111});
        e = sb_q.pop_front();
        checks++;
        if (digits !== e.digits || running !== e.running) begin
            errors++;
            $display("FAIL %s digits=%h running=%b required digits=%h running=%b",
                     e.name, digits, running, e.digits, e.running);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL spin_busy busy=%b required 1", busy);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        presc = pack_presc(100, 100, 1);
        pulse_start();
        for (int k = 1; k <= 10; k++) begin
            sb_q.push_back('{$sformatf("wrap_step%0d", k), pack_dig(0, 0, k % MODULO), 3'b111});
            tick();
            e = sb_q.pop_front();
            checks++;
            if (digits !== e.digits || running !== e.running) begin
                errors++;
                $display("FAIL %s digits=%h running=%b required digits=%h running=%b",
                         e.name, digits, running, e.digits, e.running);
            end
            checks++;
            if (!(digits[DIGIT_W-1:0] < 4'(MODULO))) begin
                errors++;
                $display("FAIL wrap_range digit=%0d required below %0d", digits[DIGIT_W-1:0], MODULO);
            end
        end
    endtask

    task automatic test_stop_sequence();
        logic [N_CH-1:0] exp_run[3];
        exp_run[0] = 3'b110;
        exp_run[1] = 3'b100;
        exp_run[2] = 3'b000;
        do_reset();
        presc = pack_presc(3, 2, 1);
        pulse_start();
        done_base = done_cnt;
        for (int s = 0; s < 3; s++) begin
            tick(4);
            stop = 1'b1;
            tick();
            stop = 1'b0;
            checks++;
            if (running !== exp_run[s]) begin
                errors++;
                $display("FAIL stopseq_run%0d running=%b required %b", s, running, exp_run[s]);
            end
            checks++;
            if (done !== (s == 2) || busy !== 1'b1) begin
                errors++;
                $display("FAIL stopseq_done%0d done=%b busy=%b required done=%b busy=1",
                         s, done, busy, (s == 2));
            end
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || done_cnt - done_base !== 1) begin
            errors++;
            $display("FAIL stopseq_after done=%b busy=%b pulses=%0d required 0 0 1",
                     done, busy, done_cnt - done_base);
        end
    endtask

    task automatic test_win();
        // Run 1: all freeze at 2 -> win.
        do_reset();
        presc = pack_presc(4, 4, 4);
        pulse_start();
        tick(8);
        stop = 1'b1;
        tick(3);
        stop = 1'b0;
        checks++;
        if (digits !== pack_dig(2, 2, 2) || done !== 1'b1 || win !== 1'b1) begin
            errors++;
            $display("FAIL win_equal digits=%h done=%b win=%b required 222 1 1", digits, done, win);
        end
        tick(3);
        checks++;
        if (win !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL win_hold win=%b busy=%b required 1 0", win, busy);
        end
        pulse_start();
        checks++;
        if (win !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL win_clear win=%b busy=%b required 0 1", win, busy);
        end
        // Run 2: freeze at 2,2,3 -> no win.
        do_reset();
        pulse_start();
        tick(8);
        stop = 1'b1;
        tick(2);
        stop = 1'b0;
        tick(2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (digits !== pack_dig(3, 2, 2) || done !== 1'b1 || win !== 1'b0) begin
            errors++;
            $display("FAIL win_unequal digits=%h done=%b win=%b required 322 1 0", digits, done, win);
        end
    endtask

    task automatic test_ignore_and_abort();
        do_reset();
        presc = pack_presc(3, 2, 1);
        pulse_start();
        tick(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(2);
        checks++;
        if (digits !== pack_dig(2, 3, 6) || running !== 3'b111 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_in_spin digits=%h running=%b busy=%b required 236 111 1",
                     digits, running, busy);
        end
        stop = 1'b1;
        tick(3);
        stop = 1'b0;
        tick();
        done_base = done_cnt;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        checks++;
        if (digits !== pack_dig(2, 3, 6) || running !== '0 || busy !== 1'b0 || done_cnt !== done_base) begin
            errors++;
            $display("FAIL stop_in_idle digits=%h running=%b busy=%b pulses=%0d required 236 000 0 0",
                     digits, running, busy, done_cnt - done_base);
        end
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (running !== 3'b111 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_and_stop running=%b busy=%b required 111 1", running, busy);
        end
        tick(3);
        done_base = done_cnt;
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        checks++;
        if (digits !== '0 || running !== '0 || busy !== 1'b0 || done !== 1'b0 || win !== 1'b0) begin
            errors++;
            $display("FAIL abort digits=%h running=%b busy=%b done=%b win=%b required all 0",
                     digits, running, busy, done, win);
        end
        rst_n = 1'b1;
        start = 1'b0;
        tick(2);
        checks++;
        if (busy !== 1'b0 || done_cnt !== done_base) begin
            errors++;
            $display("FAIL abort_after busy=%b pulses=%0d required 0 0", busy, done_cnt - done_base);
        end
    endtask

    task automatic test_stop_on_step();
        do_reset();
        presc = pack_presc(7, 5, 2);
        pulse_start();
        tick(3);
        stop = 1'b1;
        sb_q.push_back('{"stop_on_step", pack_dig(0, 0, 1), 3'b110});
        tick();
        stop = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (digits !== e.digits || running !== e.running) begin
            errors++;
            $display("FAIL %s digits=%h running=%b required digits=%h running=%b",
                     e.name, digits, running, e.digits, e.running);
        end
        sb_q.push_back('{"stopped_hold", pack_dig(1, 1, 1), 3'b110});
        tick(3);
        e = sb_q.pop_front();
        checks++;
        if (digits !== e.digits || running !== e.running) begin
            errors++;
            $display("FAIL %s digits=%h running=%b required digits=%h running=%b",
                     e.name, digits, running, e.digits, e.running);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        presc    = '0;
        @(negedge clk);
        test_reset();
        test_spin();
        test_wrap();
        test_stop_sequence();
        test_win();
        test_ignore_and_abort();
        test_stop_on_step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reel_counter_array.md
REEL_COUNTER_ARRAY -- requirements
Module: reel_counter_array

Interface
REQ-001 Parameter N_CH, default 3, number of independent digit channels (1..8).
REQ-002 Parameter DIGIT_W, default 4, width of each channel digit.
REQ-003 Parameter MODULO, default 10, digit count range 0..MODULO-1; MODULO <= 2**DIGIT_W, >= 2.
REQ-004 Parameter PRESC_W, default 32, width of each channel prescale value.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 start  input  1  single-cycle request to begin spinning all channels.
REQ-008 stop  input  1  single-cycle request to halt the lowest-index running channel.
REQ-009 presc  input  N_CH*PRESC_W  per-channel clocks-per-step; channel i at bits [i*PRESC_W +: PRESC_W].
REQ-010 digits  output  N_CH*DIGIT_W  current digit of every channel, same packing as presc.
REQ-011 running  output  N_CH  bit i high while channel i is stepping.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse when the last channel stops.
REQ-014 win  output  1  all digits equal at completion; held until next accepted start or reset.

Function
REQ-015 Controller FSM SHALL have states IDLE, SPIN, RESULT; RESULT lasts exactly one cycle then returns to IDLE.
REQ-016 In IDLE, start high SHALL at the next edge: latch presc, clear all prescaler counts, set running to all ones, clear win, enter SPIN; digits keep their values.
REQ-017 start SHALL be ignored outside IDLE; stop SHALL be ignored in IDLE and RESULT; start and stop high together in IDLE -> start accepted, stop ignored.
REQ-018 A latched prescale value of 0 SHALL be treated as 1.
REQ-019 Running channel i SHALL increment its prescale count every cycle; on the cycle count equals P_i-1 the count returns to 0 and the digit steps at that same edge (one step every P_i cycles, first step P_i cycles after start is accepted).
REQ-020 Digit step SHALL be digit+1, wrapping MODULO-1 -> 0 in one step; no intermediate value MODULO ever appears.
REQ-021 stop high in SPIN SHALL clear running[k] at the next edge, k = lowest index with running set; a digit step due on that same edge SHALL NOT be applied to channel k; other channels unaffected.
REQ-022 Stopped channels SHALL hold digit and prescale count until the next accepted start.
REQ-023 When the stop clears the final running bit, FSM SHALL enter RESULT at that same edge; in RESULT done = 1 and win = 1 iff all N_CH digits are equal (N_CH = 1 -> win = 1).
REQ-024 busy SHALL be high in SPIN and RESULT, low in IDLE.
REQ-025 presc changes after start acceptance SHALL have no effect until the next start.

Reset
REQ-026 While rst_n is low at a clock edge: state IDLE, digits all 0, running 0, prescale counts 0, latched presc 0, busy 0, done 0, win 0.
REQ-027 Reset asserted mid-SPIN or in RESULT SHALL abort without a done pulse; start in the same cycle as reset is ignored.

Structure
REQ-028 Package reel_pkg SHALL hold the FSM state enum (IDLE, SPIN, RESULT) and the default parameter constants.
REQ-029 One sub-module reel_channel SHALL implement a single prescaler plus modulo digit with inputs clear, enable and latched prescale, and output digit; instantiated N_CH times via generate.
REQ-030 The win compare and stop-priority selection SHALL reside in the top module.

Verification
REQ-031 Reset then start, presc = {3,2,1} (ch2,ch1,ch0), no stop for 12 cycles -> digits ch0=2 (wrapped from 9), ch1=6, ch2=4; running=3'b111, busy=1.
REQ-032 MODULO=10, presc ch0=1, 9 steps then 1 more -> digit sequence 0..9 then 0; never 10.
REQ-033 Three stop pulses spaced 5 cycles -> running goes 110, 100, 000; done pulses exactly once, same edge as running=000; busy low one cycle later.
REQ-034 All presc = 4, stop thrice after 8 cycles with stops timed so digits freeze at 2,2,2 -> win=1; repeat with freeze 2,2,3 -> win=0; win holds until next start.
REQ-035 start during SPIN and stop in IDLE -> no state change; rst_n low mid-SPIN -> digits 0, running 0, no done pulse.
REQ-036 stop on the exact edge ch0 would step (presc ch0 = 2) -> ch0 digit unchanged from prior value.
